key_input_conditioner: RTL and testbench

//   Conditions the raw board push-buttons before they reach the SoC KEY[1:0] input
//   (memory-mapped read at 0x80000000).
//   - Synchronises each raw button into CLK and debounces it.
//   - Normalises polarity so that 1 = pressed.
//   - Emits one-cycle press/release pulses and a sticky per-key press latch for

---
 rtl/key_input_conditioner.sv | 76 +++++++
 tb/tb_key_input_conditioner.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/key_input_conditioner.sv
// Push-button conditioner: synchronises, debounces and polarity-normalises raw keys,
// then produces registered level, press/release pulses and a sticky press latch.
module key_input_conditioner #(
    parameter int NKEYS      = 2,
    parameter int DEB_CYCLES = 50000,
    parameter int CNT_W      = 16,
    parameter int ACTIVE_LOW = 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [NKEYS-1:0] KEY_RAW,
    input  logic [NKEYS-1:0] LATCH_CLR,
    output logic [NKEYS-1:0] KEY,
    output logic [NKEYS-1:0] KEY_PRESS,
    output logic [NKEYS-1:0] KEY_REL,
    output logic [NKEYS-1:0] KEY_LATCH
);

    localparam logic [NKEYS-1:0] RAW_IDLE = (ACTIVE_LOW != 0) ? {NKEYS{1'b1}} : {NKEYS{1'b0}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [NKEYS-1:0]            s1;
    logic [NKEYS-1:0]            s2;
    logic [NKEYS-1:0]            n;
    logic [NKEYS-1:0][CNT_W-1:0] cnt;
    logic [NKEYS-1:0][CNT_W-1:0] cnt_next;
    logic [NKEYS-1:0]            key_next;
    logic [NKEYS-1:0]            press_next;
    logic [NKEYS-1:0]            rel_next;
    logic [NKEYS-1:0]            latch_next;

    assign n = (ACTIVE_LOW != 0) ? ~s2 : s2;

    // A non-zero count means the key is mid-debounce; any return to the accepted
    // level throws the partial count away.
    always_comb begin
        cnt_next   = cnt;
        key_next   = KEY;
        press_next = '0;
        rel_next   = '0;
        for (int i = 0; i < NKEYS; i++) begin
            if (n[i] == KEY[i]) begin
                cnt_next[i] = '0;
            end else if (cnt[i] == CNT_LAST) begin
                cnt_next[i]   = '0;
                key_next[i]   = n[i];
                press_next[i] = n[i];
                rel_next[i]   = ~n[i];
            end else begin
                cnt_next[i] = cnt[i] + CNT_W'(1);
            end
        end
        latch_next = press_next | (KEY_LATCH & ~LATCH_CLR);
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            s1        <= RAW_IDLE;
            s2        <= RAW_IDLE;
            cnt       <= '0;
            KEY       <= '0;
            KEY_PRESS <= '0;
            KEY_REL   <= '0;
            KEY_LATCH <= '0;
        end else begin
            s1        <= KEY_RAW;
            s2        <= s1;
            cnt       <= cnt_next;
            KEY       <= key_next;
            KEY_PRESS <= press_next;
            KEY_REL   <= rel_next;
            KEY_LATCH <= latch_next;
        end
    end

endmodule

// File: tb/tb_key_input_conditioner.sv
// Directed bench for key_input_conditioner with DEB_CYCLES=4, active-low pins;
// each step queues its expected outputs and compares them one edge later.
module tb_key_input_conditioner;

    localparam int NKEYS = 2;
    localparam int DEB   = 4;
    localparam int LAT   = DEB + 2;

    logic             CLK       = 1'b0;
    logic             RST_N     = 1'b0;
    logic [NKEYS-1:0] KEY_RAW   = 2'b11;
    logic [NKEYS-1:0] LATCH_CLR = 2'b00;
    logic [NKEYS-1:0] KEY;
    logic [NKEYS-1:0] KEY_PRESS;
    logic [NKEYS-1:0] KEY_REL;
    logic [NKEYS-1:0] KEY_LATCH;

    typedef struct {
        string      tag;
        logic [1:0] key;
        logic [1:0] press;
        logic [1:0] rel;
        logic [1:0] latch;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    key_input_conditioner #(
        .NKEYS(NKEYS),
        .DEB_CYCLES(DEB),
        .CNT_W(4),
        .ACTIVE_LOW(1)
    ) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .KEY_RAW(KEY_RAW),
        .LATCH_CLR(LATCH_CLR),
        .KEY(KEY),
        .KEY_PRESS(KEY_PRESS),
        .KEY_REL(KEY_REL),
        .KEY_LATCH(KEY_LATCH)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("[TB] FAIL scoreboard_empty: observed no entry, expected one");
            return;
        end
        e = sb.pop_front();
        checks++;
        assert (KEY === e.key) else begin
            errors++;
            $error("[TB] FAIL %s KEY: observed %b expected %b", e.tag, KEY, e.key);
        end
        checks++;
        assert (KEY_PRESS === e.press) else begin
            errors++;
            $error("[TB] FAIL %s KEY_PRESS: observed %b expected %b", e.tag, KEY_PRESS, e.press);
        end
        checks++;
        assert (KEY_REL === e.rel) else begin
            errors++;
            $error("[TB] FAIL %s KEY_REL: observed %b expected %b", e.tag, KEY_REL, e.rel);
        end
        checks++;
        assert (KEY_LATCH === e.latch) else begin
            errors++;
            $error("[TB] FAIL %s KEY_LATCH: observed %b expected %b", e.tag, KEY_LATCH, e.latch);
        end
    endtask

    // Drive one cycle of inputs, queue what the outputs must be after the next edge.
    task automatic applyStimulus(input string tag, input logic rstn, input logic [1:0] raw,
                                 input logic [1:0] clr, input logic [1:0] key,
                                 input logic [1:0] press, input logic [1:0] rel,
                                 input logic [1:0] latch);
        exp_t e;
        RST_N     = rstn;
        KEY_RAW   = raw;
        LATCH_CLR = clr;
        e.tag     = tag;
        e.key     = key;
        e.press   = press;
        e.rel     = rel;
        e.latch   = latch;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        checkOutput();
    endtask

    task automatic hold(input string tag, input int cycles, input logic [1:0] raw,
                        input logic [1:0] clr, input logic [1:0] key, input logic [1:0] latch);
        for (int i = 0; i < cycles; i++)
            applyStimulus(tag, 1'b1, raw, clr, key, 2'b00, 2'b00, latch);
    endtask

    // New raw level held: old KEY for LAT-1 edges, then the change with its pulse.
    task automatic settle(input string tag, input logic [1:0] raw, input logic [1:0] clr_last,
                          input logic [1:0] old_key, input logic [1:0] new_key,
                          input logic [1:0] latch_before, input logic [1:0] latch_after);
        hold(tag, LAT - 1, raw, 2'b00, old_key, latch_before);
        applyStimulus(tag, 1'b1, raw, clr_last, new_key, new_key & ~old_key,
                      old_key & ~new_key, latch_after);
    endtask

    initial begin
        for (int i = 0; i < 10; i++)
            applyStimulus("reset", 1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        hold("idle", 2, 2'b11, 2'b00, 2'b00, 2'b00);

        settle("press0", 2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01);
        hold("press0_held", 2, 2'b10, 2'b00, 2'b01, 2'b01);
        settle("rel0", 2'b11, 2'b00, 2'b01, 2'b00, 2'b01, 2'b01);
        hold("idle2", 1, 2'b11, 2'b00, 2'b00, 2'b01);

        hold("glitch1", 3, 2'b01, 2'b00, 2'b00, 2'b01);
        hold("glitch1_end", 4, 2'b11, 2'b00, 2'b00, 2'b01);
        settle("press1", 2'b01, 2'b00, 2'b00, 2'b10, 2'b01, 2'b11);
        settle("rel1", 2'b11, 2'b00, 2'b10, 2'b00, 2'b11, 2'b11);
        applyStimulus("clr1", 1'b1, 2'b11, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01);
        hold("clr1_after", 1, 2'b11, 2'b00, 2'b00, 2'b01);

        applyStimulus("clr0", 1'b1, 2'b11, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
        applyStimulus("clr0_when_zero", 1'b1, 2'b11, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
        settle("press0_set_wins", 2'b10, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01);
        applyStimulus("latch_kept", 1'b1, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01);
        applyStimulus("clr0_late", 1'b1, 2'b10, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
        applyStimulus("clr0_done", 1'b1, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);

        settle("rel0b", 2'b11, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
        hold("press0_partial", 4, 2'b10, 2'b00, 2'b00, 2'b00);
        applyStimulus("mid_reset", 1'b0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        settle("press0_after_reset", 2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01);
        hold("press0_after_reset_held", 1, 2'b10, 2'b00, 2'b01, 2'b01);

        settle("rel0c", 2'b11, 2'b00, 2'b01, 2'b00, 2'b01, 2'b01);
        settle("both_press", 2'b00, 2'b00, 2'b00, 2'b11, 2'b01, 2'b11);
        applyStimulus("both_held", 1'b1, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b11);
        checks++;
        assert (32'(KEY) === 32'd3) else begin
            errors++;
            $error("[TB] FAIL soc_key_read: observed %0d expected 3", KEY);
        end
        settle("both_rel", 2'b11, 2'b00, 2'b11, 2'b00, 2'b11, 2'b11);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
